// File: rtl/urp_pcie_pkg.sv
// urp_pcie_pkg: shared widths, beat-count derivation and beat flag type for the PCIe egress path.
package urp_pcie_pkg;

   localparam int DATA_SIZE_DEF = 224;
   localparam int BEAT_W_DEF    = 32;

   function automatic int n_beats(int data_size, int beat_w);
      return data_size / beat_w;
   endfunction

   localparam int N_BEATS_DEF = n_beats(DATA_SIZE_DEF, BEAT_W_DEF);

   typedef struct packed {
      logic sop;
      logic eop;
   } beat_flags_t;

endpackage

// File: rtl/urp_pcie_tlp_serializer_if.sv
// urp_pcie_tlp_serializer_if: arbiter-side word handshake and link-side beat handshake.
// dst_par_o exists only when URP_PCIE_SER_PARITY_EN is defined.
interface urp_pcie_tlp_serializer_if #(
   parameter int DATA_SIZE = urp_pcie_pkg::DATA_SIZE_DEF,
   parameter int BEAT_W    = urp_pcie_pkg::BEAT_W_DEF
);
   logic                 src_valid_i;
   logic                 src_ready_o;
   logic [DATA_SIZE-1:0] src_data_i;
   logic                 dst_valid_o;
   logic                 dst_ready_i;
   logic [BEAT_W-1:0]    dst_data_o;
   logic                 dst_sop_o;
   logic                 dst_eop_o;
`ifdef URP_PCIE_SER_PARITY_EN
   logic                 dst_par_o;
`endif

   modport slave (
      input  src_valid_i, src_data_i, dst_ready_i,
      output src_ready_o, dst_valid_o, dst_data_o, dst_sop_o, dst_eop_o
`ifdef URP_PCIE_SER_PARITY_EN
      , dst_par_o
`endif
   );

   modport master (
      output src_valid_i, src_data_i, dst_ready_i,
      input  src_ready_o, dst_valid_o, dst_data_o, dst_sop_o, dst_eop_o
`ifdef URP_PCIE_SER_PARITY_EN
      , dst_par_o
`endif
   );

endinterface

// File: rtl/urp_pcie_sync_fifo.sv
// urp_pcie_sync_fifo: small synchronous FIFO with occupancy count; no same-cycle write-through when full.
module urp_pcie_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   cnt_o,
   output logic [WIDTH-1:0]         head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    cnt_q;
   logic             wr, rd;

   assign full_o = cnt_q == CW'(DEPTH);
   assign wr     = push_i && !full_o;
   assign rd     = pop_i && cnt_q != '0;
   assign cnt_o  = cnt_q;
   assign head_o = mem_q[rptr_q];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (rd) rptr_q <= rptr_q + AW'(1);
         cnt_q <= cnt_q + CW'(wr) - CW'(rd);
      end
   end

endmodule

// File: rtl/urp_pcie_tlp_serializer.sv
// urp_pcie_tlp_serializer: buffers 224-bit TLP words and emits them MSB-first as 32-bit beats with sop/eop.
// Define URP_PCIE_SER_PARITY_EN to add the dst_par_o even-parity output.
module urp_pcie_tlp_serializer
   import urp_pcie_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int BEAT_W    = BEAT_W_DEF,
   parameter int DEPTH     = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   urp_pcie_tlp_serializer_if.slave    bus
);

   localparam int N_BEATS = n_beats(DATA_SIZE, BEAT_W);
   localparam int BCW     = N_BEATS > 1 ? $clog2(N_BEATS) : 1;
   localparam int FCW     = $clog2(DEPTH) + 1;

   typedef enum logic {IDLE, STREAM} state_e;

   state_e               state_q;
   logic [BCW-1:0]       beat_q;
   logic                 full, valid, push, fire, last, pop;
   logic [FCW-1:0]       cnt;
   logic [DATA_SIZE-1:0] head;
   logic [BEAT_W-1:0]    beat;
   beat_flags_t          flags;

   assign valid = state_q == STREAM;
   assign push  = bus.src_valid_i && !full;
   assign fire  = valid && bus.dst_ready_i;
   assign last  = beat_q == BCW'(N_BEATS - 1);
   assign pop   = fire && last;

   urp_pcie_sync_fifo #(.WIDTH(DATA_SIZE), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push),
      .pop_i  (pop),
      .data_i (bus.src_data_i),
      .full_o (full),
      .cnt_o  (cnt),
      .head_o (head)
   );

   // Leaving STREAM only when the last buffered word retires with nothing arriving behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= push ? STREAM : (pop && cnt == FCW'(1)) ? IDLE : state_q;
         if (fire) beat_q <= last ? '0 : beat_q + BCW'(1);
      end
   end

   assign beat  = head[DATA_SIZE-1-int'(beat_q)*BEAT_W -: BEAT_W];
   assign flags = '{sop: valid && beat_q == '0, eop: valid && last};

   assign bus.src_ready_o = !full;
   assign bus.dst_valid_o = valid;
   assign bus.dst_data_o  = valid ? beat : '0;
   assign bus.dst_sop_o   = flags.sop;
   assign bus.dst_eop_o   = flags.eop;
`ifdef URP_PCIE_SER_PARITY_EN
   assign bus.dst_par_o   = ^bus.dst_data_o;
`endif

endmodule

// File: tb/tb_urp_pcie_tlp_serializer.sv
// tb_urp_pcie_tlp_serializer: directed scenarios plus randomized traffic against a queue-based word/beat model.
// Parity checks are compiled in when URP_PCIE_SER_PARITY_EN is defined.
module tb_urp_pcie_tlp_serializer;
   import urp_pcie_pkg::*;

   localparam int DW    = DATA_SIZE_DEF;
   localparam int BW    = BEAT_W_DEF;
   localparam int NB    = N_BEATS_DEF;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   urp_pcie_tlp_serializer_if bus ();

   urp_pcie_tlp_serializer #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // {valid, sop, eop, data} expected while beat k of word w is presented.
   function automatic logic [BW+2:0] beat_exp(logic [DW-1:0] w, int k);
      return {1'b1, 1'(k == 0), 1'(k == NB - 1), BW'(w >> ((NB - 1 - k) * BW))};
   endfunction

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [BW+2:0] obs();
      return {bus.dst_valid_o, bus.dst_sop_o, bus.dst_eop_o, bus.dst_data_o};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      bus.src_valid_i = 1'b1;
      bus.src_data_i = rnd_word();
      bus.dst_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (obs() !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", obs()); end
      checks++;
      if (bus.src_ready_o !== 1'b1) begin errors++; $display("FAIL reset_src_ready got %b exp 1", bus.src_ready_o); end
`ifdef URP_PCIE_SER_PARITY_EN
      checks++;
      if (bus.dst_par_o !== 1'b0) begin errors++; $display("FAIL reset_par got %b exp 0", bus.dst_par_o); end
`endif
      bus.src_valid_i = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.dst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_release_valid got %b exp 0", bus.dst_valid_o); end
   endtask

   task automatic test_single();
      logic [DW-1:0] w = '0;
      for (int k = 0; k < NB; k++) w = {w[DW-BW-1:0], BW'(k + 1)};
      bus.src_valid_i = 1'b1;
      bus.src_data_i = w;
      bus.dst_ready_i = 1'b1;
      @(negedge clk);
      bus.src_valid_i = 1'b0;
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (obs() !== {1'b1, 1'(k == 0), 1'(k == NB - 1), BW'(k + 1)})
            begin errors++; $display("FAIL single_beat%0d got %h exp beat %0d", k, obs(), k + 1); end
`ifdef URP_PCIE_SER_PARITY_EN
         checks++;
         if (bus.dst_par_o !== ^BW'(k + 1))
            begin errors++; $display("FAIL single_par%0d got %b exp %b", k, bus.dst_par_o, ^BW'(k + 1)); end
`endif
         @(negedge clk);
      end
      checks++;
      if (obs() >> BW !== 3'b000) begin errors++; $display("FAIL single_idle got %h exp flags 0", obs()); end
   endtask

   task automatic test_fill();
      logic [DW-1:0] a = rnd_word(), b = rnd_word(), c = rnd_word(), w;
      bus.dst_ready_i = 1'b0;
      bus.src_valid_i = 1'b1;
      bus.src_data_i = a;
      @(negedge clk);
      checks++;
      if (bus.src_ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready1 got %b exp 1", bus.src_ready_o); end
      bus.src_data_i = b;
      @(negedge clk);
      bus.src_data_i = c;
      repeat (2) begin
         checks++;
         if (bus.src_ready_o !== 1'b0) begin errors++; $display("FAIL fill_full got %b exp 0", bus.src_ready_o); end
         checks++;
         if (obs() !== beat_exp(a, 0)) begin errors++; $display("FAIL fill_hold got %h exp %h", obs(), beat_exp(a, 0)); end
         @(negedge clk);
      end
      bus.dst_ready_i = 1'b1;
      for (int i = 0; i < 3 * NB; i++) begin
         if (i == NB + 1) bus.src_valid_i = 1'b0;
         w = i < NB ? a : i < 2 * NB ? b : c;
         checks++;
         if (obs() !== beat_exp(w, i % NB)) begin errors++; $display("FAIL fill_drain%0d got %h exp %h", i, obs(), beat_exp(w, i % NB)); end
         if (i <= NB + 1) begin
            checks++;
            if (bus.src_ready_o !== 1'(i == NB))
               begin errors++; $display("FAIL fill_src_ready%0d got %b exp %b", i, bus.src_ready_o, i == NB); end
         end
         @(negedge clk);
      end
      checks++;
      if (bus.dst_valid_o !== 1'b0) begin errors++; $display("FAIL fill_idle got %b exp 0", bus.dst_valid_o); end
   endtask

   task automatic test_stall();
      logic [DW-1:0] w = rnd_word();
      bus.dst_ready_i = 1'b1;
      bus.src_valid_i = 1'b1;
      bus.src_data_i = w;
      @(negedge clk);
      bus.src_valid_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs() !== beat_exp(w, k)) begin errors++; $display("FAIL stall_pre%0d got %h exp %h", k, obs(), beat_exp(w, k)); end
         @(negedge clk);
      end
      bus.dst_ready_i = 1'b0;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (obs() !== beat_exp(w, 2)) begin errors++; $display("FAIL stall_hold got %h exp %h", obs(), beat_exp(w, 2)); end
      end
      bus.dst_ready_i = 1'b1;
      @(negedge clk);
      for (int k = 3; k < NB; k++) begin
         checks++;
         if (obs() !== beat_exp(w, k)) begin errors++; $display("FAIL stall_post%0d got %h exp %h", k, obs(), beat_exp(w, k)); end
         @(negedge clk);
      end
      checks++;
      if (bus.dst_valid_o !== 1'b0) begin errors++; $display("FAIL stall_idle got %b exp 0", bus.dst_valid_o); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] a = rnd_word(), b = rnd_word();
      bus.dst_ready_i = 1'b0;
      bus.src_valid_i = 1'b1;
      bus.src_data_i = a;
      @(negedge clk);
      bus.src_data_i = b;
      @(negedge clk);
      bus.src_valid_i = 1'b0;
      bus.dst_ready_i = 1'b1;
      for (int i = 0; i < 2 * NB; i++) begin
         checks++;
         if (obs() !== beat_exp(i < NB ? a : b, i % NB))
            begin errors++; $display("FAIL b2b_beat%0d got %h exp %h", i, obs(), beat_exp(i < NB ? a : b, i % NB)); end
         @(negedge clk);
      end
      checks++;
      if (bus.dst_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", bus.dst_valid_o); end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] w = rnd_word();
      bus.dst_ready_i = 1'b1;
      bus.src_valid_i = 1'b1;
      bus.src_data_i = w;
      @(negedge clk);
      bus.src_data_i = rnd_word();
      @(negedge clk);
      bus.src_valid_i = 1'b0;
      for (int k = 1; k < 4; k++) @(negedge clk);
      checks++;
      if (obs() !== beat_exp(w, 4)) begin errors++; $display("FAIL rstmid_beat5 got %h exp %h", obs(), beat_exp(w, 4)); end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (obs() !== '0) begin errors++; $display("FAIL rstmid_outputs got %h exp 0", obs()); end
      checks++;
      if (bus.src_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_src_ready got %b exp 1", bus.src_ready_o); end
`ifdef URP_PCIE_SER_PARITY_EN
      checks++;
      if (bus.dst_par_o !== 1'b0) begin errors++; $display("FAIL rstmid_par got %b exp 0", bus.dst_par_o); end
`endif
      bus.src_valid_i = 1'b1;
      repeat (2) @(negedge clk);
      bus.src_valid_i = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.dst_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_flushed got %b exp 0", bus.dst_valid_o); end
      bus.src_valid_i = 1'b1;
      bus.src_data_i = '1;
      @(negedge clk);
      bus.src_valid_i = 1'b0;
      for (int k = 0; k < NB; k++) begin
         checks++;
         if (obs() !== {1'b1, 1'(k == 0), 1'(k == NB - 1), {BW{1'b1}}})
            begin errors++; $display("FAIL rstmid_new%0d got %h exp ones", k, obs()); end
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] q[$];
      logic [DW-1:0] head;
      logic [BW+2:0] exp_o;
      logic          v, r, push;
      int            k = 0;
      rst_n = 1'b0;
      bus.src_valid_i = 1'b0;
      bus.dst_ready_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (600) begin
         head  = q.size() > 0 ? q[0] : '0;
         exp_o = q.size() > 0 ? beat_exp(head, k) : '0;
         checks++;
         if (obs() !== exp_o) begin errors++; $display("FAIL rand_beat got %h exp %h", obs(), exp_o); end
         checks++;
         if (bus.src_ready_o !== 1'(q.size() < DEPTH))
            begin errors++; $display("FAIL rand_src_ready got %b exp %b", bus.src_ready_o, q.size() < DEPTH); end
`ifdef URP_PCIE_SER_PARITY_EN
         checks++;
         if (bus.dst_par_o !== ^exp_o[BW-1:0]) begin errors++; $display("FAIL rand_par got %b exp %b", bus.dst_par_o, ^exp_o[BW-1:0]); end
`endif
         v = $urandom_range(0, 2) != 0;
         r = $urandom_range(0, 3) != 0;
         bus.src_valid_i = v;
         bus.src_data_i = rnd_word();
         bus.dst_ready_i = r;
         push = v && q.size() < DEPTH;
         if (q.size() > 0 && r) begin
            if (k == NB - 1) begin
               void'(q.pop_front());
               k = 0;
            end else k++;
         end
         if (push) q.push_back(bus.src_data_i);
         @(negedge clk);
      end
      bus.src_valid_i = 1'b0;
   endtask

   initial begin
      bus.src_valid_i = 1'b0;
      bus.src_data_i = '0;
      bus.dst_ready_i = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_fill();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/urp_pcie_tlp_serializer.md
# urp_pcie_tlp_serializer

Egress width converter placed directly downstream of the two-master PCIe arbiter. It accepts whole 224-bit arbitrated TLP words on a valid/ready handshake and buffers them in a small FIFO. It emits each word as a burst of 32-bit beats, marked with start-of-packet and end-of-packet flags, toward the link-layer interface. Backpressure from the link side propagates to the arbiter through `src_ready_o`.

## Interface
- `DATA_SIZE`, 224: input word width; must be an integer multiple of `BEAT_W`.
- `BEAT_W`, 32: output beat width.
- `DEPTH`, 2: input FIFO entries; power of two, ≥2.
- `clk` input 1: clock, all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `src_valid_i` input 1: arbiter word valid.
- `src_ready_o` output 1: FIFO can accept a word.
- `src_data_i` input DATA_SIZE: arbiter word.
- `dst_valid_o` output 1: beat valid.
- `dst_ready_i` input 1: link side accepts beat.
- `dst_data_o` output BEAT_W: current beat.
- `dst_sop_o` output 1: first beat of a word.
- `dst_eop_o` output 1: last beat of a word.
- `dst_par_o` output 1: beat parity; present only with `URP_PCIE_SER_PARITY_EN`.

## Operation
- `N_BEATS = DATA_SIZE/BEAT_W` (7 at defaults). The beat counter is `$clog2(N_BEATS)` bits wide and counts 0..N_BEATS-1.
- FIFO state: write pointer, read pointer, and an occupancy count `cnt` of width `$clog2(DEPTH)+1`. Pointers wrap modulo DEPTH.
- Push: a word is pushed when `src_valid_i && src_ready_o`. `src_ready_o = (cnt != DEPTH)` is combinational from registered state. There is no same-cycle pass-through, so a full FIFO rejects the word even if a pop occurs in the same cycle.
- Pop: the head entry is popped when `dst_valid_o && dst_ready_i && dst_eop_o`. A simultaneous push and pop leaves `cnt` unchanged.
- Output state machine:
  - IDLE: `cnt==0`, `dst_valid_o=0`.
  - STREAM: `cnt>0`, `dst_valid_o=1`.
  - Transitions: IDLE→STREAM on push. STREAM→IDLE on the final pop with no concurrent push. STREAM→STREAM otherwise.
- Beat order is most-significant first. Beat `k` is `head[DATA_SIZE-1-k*BEAT_W -: BEAT_W]`, so beat 0 at defaults is bits [223:192].
- Flags: `dst_sop_o = (beat_cnt==0)`; `dst_eop_o = (beat_cnt==N_BEATS-1)`. Both flags are qualified by `dst_valid_o`, i.e. both are 0 when idle.
- Beat handshake: on `dst_valid_o && dst_ready_i`, `beat_cnt` increments. At N_BEATS-1 it wraps to 0 together with the pop.
- Stall: while `dst_ready_i=0`, `dst_data_o`, `dst_sop_o`, `dst_eop_o` and `beat_cnt` hold stable.
- `dst_ready_i` may be asserted while idle; it has no effect.
- `src_data_i` is sampled only on the push edge.

## Timing
- Reset values:
  - `dst_valid_o=0`, `dst_sop_o=0`, `dst_eop_o=0`, `dst_data_o=0`, `dst_par_o=0`.
  - `src_ready_o=1`; pushes are ignored while `rst_n` is low.
  - `cnt`, pointers and `beat_cnt` are 0; FIFO storage is cleared to 0.
- Latency: a word pushed at edge N produces beat 0 valid immediately after edge N. Its eop is at the earliest after edge N+N_BEATS-1.
- Throughput: one beat per cycle with `dst_ready_i` held high. Words stream back-to-back with no idle cycle: eop of word A is followed directly by sop of word B.
- Output paths: `dst_data_o` is a combinational mux from registered storage and `beat_cnt`; it has no path from `src_*` inputs. `src_ready_o` has no combinational path from `dst_ready_i`.
- Reset mid-word: the partial word and all buffered words are discarded. The next sop follows the first push after reset release.

## Configuration
- `URP_PCIE_SER_PARITY_EN` defined:
  - Adds output `dst_par_o = ^dst_data_o`, giving even parity over beat plus parity bit.
  - `dst_par_o` is combinational, tracks `dst_data_o`, and is 0 when idle.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- `urp_pcie_pkg` holds the `DATA_SIZE` and `BEAT_W` default localparams and the `N_BEATS` derivation. It also holds a `beat_flags_t` packed struct `{sop, eop}` shared with the link-layer consumer.
- Sub-module `urp_pcie_sync_fifo` (parameters WIDTH, DEPTH) owns storage, pointers, `cnt`, full/empty and head read.
- The top level owns the beat counter, the slice mux, the flags and parity.

## Test plan
- Single word `0x0000_0001_..._0000_0007` (beats 1..7), `dst_ready_i=1`:
  - beats 1,2,…,7 appear on 7 consecutive cycles starting the cycle after the push;
  - sop is high on beat 1 only and eop on beat 7 only;
  - afterwards `dst_valid_o=0`.
- Fill: three words pushed with `dst_ready_i=0`:
  - the first two are accepted;
  - `src_ready_o=0` while `cnt=2`, so the third is held off;
  - asserting `dst_ready_i` drains 14 beats in order, and the third word is accepted on the cycle after the first eop.
- Stall mid-word: `dst_ready_i` is dropped on beat 3 for 4 cycles; beat 3's data and flags hold unchanged, then beats 4..7 follow.
- Back-to-back: words A and B are buffered; A's eop is followed immediately by B's sop with no gap in `dst_valid_o`.
- Reset during beat 5 of 7:
  - all outputs return to their reset values and `cnt=0`;
  - after release, a new word `0xFF..FF` starts at sop with beat `0xFFFFFFFF`.
- With `URP_PCIE_SER_PARITY_EN` defined: beat `0x0000_0007` gives `dst_par_o=1` and beat `0x0000_0003` gives `dst_par_o=0`.
